// File: rtl/cpu_control_unit.sv
// Multi-cycle instruction sequencer: fetches 16-bit words, decodes register fields,
// optionally fetches an immediate extension word and strobes one register-file write.
module cpu_control_unit #(
    parameter int          PC_W      = 8,
    parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [15:0]     Instr,
    input  logic            Instr_Valid,
    output logic            Instr_Ready,
    output logic [PC_W-1:0] PC,
    input  logic            N,
    input  logic            Z,
    input  logic            C,
    output logic            W_En,
    output logic [2:0]      W_Adr,
    output logic [2:0]      R_Adr,
    output logic [2:0]      S_Adr,
    output logic            S_Sel,
    output logic [15:0]     DS,
    output logic [3:0]      ALU_OP,
    output logic [2:0]      Flags,
    output logic            Halted,
    output logic [15:0]     Instr_Count
);

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        FETCH_IMM = 3'd2,
        EXECUTE   = 3'd3,
        HALT      = 3'd4
    } state_t;

    state_t          state_r;
    state_t          next_state_s;
    logic            accept_s;
    logic [15:0]     ir_r;
    logic [15:0]     ds_r;
    logic [15:0]     count_r;
    logic [PC_W-1:0] pc_r;
    logic [2:0]      flags_r;
    logic            instr_ready_r;
    logic            w_en_r;
    logic            halted_r;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

    // Next-state selection and word-acceptance handshake
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            FETCH, FETCH_IMM: begin
                if (Instr_Valid && instr_ready_r) begin
                    accept_s     = 1'b1;
                    next_state_s = (state_r == FETCH) ? DECODE : EXECUTE;
                end else begin
                    next_state_s = state_r;
                end
            end
            DECODE: begin
                if (ir_r == HALT_WORD) begin
                    next_state_s = HALT;
                end else if (ir_r[2]) begin
                    next_state_s = FETCH_IMM;
                end else begin
                    next_state_s = EXECUTE;
                end
            end
            EXECUTE: next_state_s = FETCH;
            HALT:    next_state_s = HALT;
            default: next_state_s = FETCH;
        endcase
    end

    // State, architectural registers and registered per-state strobes
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r       <= FETCH;
            pc_r          <= {PC_W{1'b0}};
            ir_r          <= 16'h0000;
            ds_r          <= 16'h0000;
            flags_r       <= 3'b000;
            count_r       <= 16'h0000;
            instr_ready_r <= 1'b1;
            w_en_r        <= 1'b0;
            halted_r      <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            instr_ready_r <= (next_state_s == FETCH) || (next_state_s == FETCH_IMM);
            w_en_r        <= (next_state_s == EXECUTE);
            halted_r      <= (next_state_s == HALT);
            if (accept_s) begin
                pc_r <= pc_r + PC_W'(1);
                if (state_r == FETCH) begin
                    ir_r <= Instr;
                end else begin
                    ds_r <= Instr;
                end
            end
            if (state_r == EXECUTE) begin
                flags_r <= {N, Z, C};
                count_r <= sat_inc(count_r);
            end
        end
    end

    // The write strobe is masked by Reset so a reset landing in EXECUTE never writes
    assign W_En        = w_en_r & ~Reset;
    assign Instr_Ready = instr_ready_r;
    assign Halted      = halted_r;
    assign PC          = pc_r;
    assign ALU_OP      = ir_r[15:12];
    assign W_Adr       = ir_r[11:9];
    assign R_Adr       = ir_r[8:6];
    assign S_Adr       = ir_r[5:3];
    assign S_Sel       = ir_r[2];
    assign DS          = ds_r;
    assign Flags       = flags_r;
    assign Instr_Count = count_r;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: a table of per-cycle vectors plus
// hand-written reset-in-flight and PC wrap sequences.
module tb_cpu_control_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] Instr;
    logic        Instr_Valid;
    logic        Instr_Ready;
    logic [7:0]  PC;
    logic        N, Z, C;
    logic        W_En;
    logic [2:0]  W_Adr, R_Adr, S_Adr;
    logic        S_Sel;
    logic [15:0] DS;
    logic [3:0]  ALU_OP;
    logic [2:0]  Flags;
    logic        Halted;
    logic [15:0] Instr_Count;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    cpu_control_unit dut (
        .Clk(Clk), .Reset(Reset), .Instr(Instr), .Instr_Valid(Instr_Valid),
        .Instr_Ready(Instr_Ready), .PC(PC), .N(N), .Z(Z), .C(C), .W_En(W_En),
        .W_Adr(W_Adr), .R_Adr(R_Adr), .S_Adr(S_Adr), .S_Sel(S_Sel), .DS(DS),
        .ALU_OP(ALU_OP), .Flags(Flags), .Halted(Halted), .Instr_Count(Instr_Count)
    );

    typedef struct {
        logic        rst;
        logic        vld;
        logic [15:0] ins;
        logic [2:0]  nzc;
        logic        rdy;
        logic        wen;
        logic [7:0]  pc;
        logic        hlt;
        logic [15:0] cnt;
        logic [2:0]  flg;
        logic [15:0] ds;
        logic        ssel;
        logic [3:0]  op;
        logic [2:0]  wadr;
        logic [2:0]  radr;
        logic [2:0]  sadr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic vld, input logic [15:0] ins,
                                input logic [2:0] nzc, input logic rdy, input logic wen,
                                input logic [7:0] pc, input logic hlt, input logic [15:0] cnt,
                                input logic [2:0] flg, input logic [15:0] ds, input logic ssel,
                                input logic [3:0] op, input logic [2:0] wadr,
                                input logic [2:0] radr, input logic [2:0] sadr);
        vec_t v;
        v.rst = rst; v.vld = vld; v.ins = ins; v.nzc = nzc;
        v.rdy = rdy; v.wen = wen; v.pc = pc; v.hlt = hlt; v.cnt = cnt; v.flg = flg;
        v.ds = ds; v.ssel = ssel; v.op = op; v.wadr = wadr; v.radr = radr; v.sadr = sadr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic vld, input logic [15:0] ins, input logic [2:0] nzc);
        Reset = rst; Instr_Valid = vld; Instr = ins; {N, Z, C} = nzc;
    endtask

    int wen_pulses;

    initial begin
        drive(1'b1, 1'b0, 16'h0000, 3'b000);

        //          rst   vld   ins       nzc     rdy   wen   pc     hlt   cnt     flg     ds        ssel  op     wadr  radr  sadr
        vecs.push_back(mk(1'b1, 1'b0, 16'h0000, 3'b000, 1'b1, 1'b0, 8'd0, 1'b0, 16'd0, 3'b000, 16'h0000, 1'b0, 4'h0, 3'd0, 3'd0, 3'd0)); // reset
        vecs.push_back(mk(1'b0, 1'b1, 16'h1250, 3'b000, 1'b0, 1'b0, 8'd1, 1'b0, 16'd0, 3'b000, 16'h0000, 1'b0, 4'h1, 3'd1, 3'd1, 3'd2)); // fetch -> DECODE
        vecs.push_back(mk(1'b0, 1'b1, 16'h1250, 3'b101, 1'b0, 1'b1, 8'd1, 1'b0, 16'd0, 3'b000, 16'h0000, 1'b0, 4'h1, 3'd1, 3'd1, 3'd2)); // EXECUTE
        vecs.push_back(mk(1'b0, 1'b1, 16'h3000, 3'b101, 1'b1, 1'b0, 8'd1, 1'b0, 16'd1, 3'b101, 16'h0000, 1'b0, 4'h1, 3'd1, 3'd1, 3'd2)); // write edge
        vecs.push_back(mk(1'b0, 1'b1, 16'h2204, 3'b000, 1'b0, 1'b0, 8'd2, 1'b0, 16'd1, 3'b101, 16'h0000, 1'b1, 4'h2, 3'd1, 3'd0, 3'd0)); // imm op DECODE
        vecs.push_back(mk(1'b0, 1'b1, 16'h00AB, 3'b000, 1'b1, 1'b0, 8'd2, 1'b0, 16'd1, 3'b101, 16'h0000, 1'b1, 4'h2, 3'd1, 3'd0, 3'd0)); // FETCH_IMM, word ignored
        for (int k = 0; k < 5; k++) begin
            vecs.push_back(mk(1'b0, 1'b0, 16'h00AB, 3'b000, 1'b1, 1'b0, 8'd2, 1'b0, 16'd1, 3'b101, 16'h0000, 1'b1, 4'h2, 3'd1, 3'd0, 3'd0)); // stall
        end
        vecs.push_back(mk(1'b0, 1'b1, 16'h00AB, 3'b010, 1'b0, 1'b1, 8'd3, 1'b0, 16'd1, 3'b101, 16'h00AB, 1'b1, 4'h2, 3'd1, 3'd0, 3'd0)); // imm accepted
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 3'b010, 1'b1, 1'b0, 8'd3, 1'b0, 16'd2, 3'b010, 16'h00AB, 1'b1, 4'h2, 3'd1, 3'd0, 3'd0)); // write edge
        vecs.push_back(mk(1'b0, 1'b1, 16'hFFFF, 3'b000, 1'b0, 1'b0, 8'd4, 1'b0, 16'd2, 3'b010, 16'h00AB, 1'b1, 4'hF, 3'd7, 3'd7, 3'd7)); // halt word DECODE
        vecs.push_back(mk(1'b0, 1'b1, 16'h1250, 3'b111, 1'b0, 1'b0, 8'd4, 1'b1, 16'd2, 3'b010, 16'h00AB, 1'b1, 4'hF, 3'd7, 3'd7, 3'd7)); // HALT
        vecs.push_back(mk(1'b0, 1'b1, 16'h1250, 3'b111, 1'b0, 1'b0, 8'd4, 1'b1, 16'd2, 3'b010, 16'h00AB, 1'b1, 4'hF, 3'd7, 3'd7, 3'd7)); // HALT frozen
        vecs.push_back(mk(1'b1, 1'b1, 16'h1250, 3'b111, 1'b1, 1'b0, 8'd0, 1'b0, 16'd0, 3'b000, 16'h0000, 1'b0, 4'h0, 3'd0, 3'd0, 3'd0)); // reset exits HALT

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].vld, vecs[i].ins, vecs[i].nzc);
            tick();
            chk($sformatf("v%0d.ready", i),  32'(Instr_Ready), 32'(vecs[i].rdy));
            chk($sformatf("v%0d.w_en", i),   32'(W_En),        32'(vecs[i].wen));
            chk($sformatf("v%0d.pc", i),     32'(PC),          32'(vecs[i].pc));
            chk($sformatf("v%0d.halted", i), 32'(Halted),      32'(vecs[i].hlt));
            chk($sformatf("v%0d.count", i),  32'(Instr_Count), 32'(vecs[i].cnt));
            chk($sformatf("v%0d.flags", i),  32'(Flags),       32'(vecs[i].flg));
            chk($sformatf("v%0d.ds", i),     32'(DS),          32'(vecs[i].ds));
            chk($sformatf("v%0d.s_sel", i),  32'(S_Sel),       32'(vecs[i].ssel));
            chk($sformatf("v%0d.alu_op", i), 32'(ALU_OP),      32'(vecs[i].op));
            chk($sformatf("v%0d.w_adr", i),  32'(W_Adr),       32'(vecs[i].wadr));
            chk($sformatf("v%0d.r_adr", i),  32'(R_Adr),       32'(vecs[i].radr));
            chk($sformatf("v%0d.s_adr", i),  32'(S_Adr),       32'(vecs[i].sadr));
        end

        // Reset landing in EXECUTE with all flags set
        drive(1'b0, 1'b1, 16'h1250, 3'b000);
        tick();
        drive(1'b0, 1'b0, 16'h0000, 3'b000);
        tick();
        chk("rst_exec.w_en_before", 32'(W_En), 32'd1);
        drive(1'b1, 1'b0, 16'h0000, 3'b111);
        #1;
        chk("rst_exec.w_en_masked", 32'(W_En), 32'd0);
        tick();
        chk("rst_exec.flags", 32'(Flags),       32'd0);
        chk("rst_exec.count", 32'(Instr_Count), 32'd0);
        chk("rst_exec.pc",    32'(PC),          32'd0);
        chk("rst_exec.w_en",  32'(W_En),        32'd0);
        drive(1'b0, 1'b0, 16'h0000, 3'b111);
        tick();
        chk("rst_exec.w_en_after", 32'(W_En),        32'd0);
        chk("rst_exec.ready",      32'(Instr_Ready), 32'd1);
        chk("rst_exec.flags_hold", 32'(Flags),       32'd0);

        // Reset landing in FETCH_IMM discards the pending immediate
        drive(1'b0, 1'b1, 16'h2204, 3'b000);
        tick();
        drive(1'b0, 1'b0, 16'h0000, 3'b000);
        tick();
        drive(1'b1, 1'b1, 16'h00CD, 3'b000);
        tick();
        chk("rst_imm.pc", 32'(PC), 32'd0);
        chk("rst_imm.ds", 32'(DS), 32'd0);
        drive(1'b0, 1'b0, 16'h0000, 3'b000);
        tick();
        chk("rst_imm.w_en", 32'(W_En), 32'd0);

        // 256 back-to-back register ops wrap the PC
        wen_pulses = 0;
        drive(1'b0, 1'b1, 16'h1250, 3'b000);
        for (int n = 0; n < 256; n++) begin
            for (int t = 0; t < 3; t++) begin
                tick();
                if (W_En) wen_pulses++;
            end
            if (n == 254) chk("wrap.pc_255", 32'(PC), 32'd255);
        end
        chk("wrap.pc",     32'(PC),          32'd0);
        chk("wrap.count",  32'(Instr_Count), 32'd256);
        chk("wrap.pulses", 32'(wen_pulses),  32'd256);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
